quad_mem_arb: RTL

Two-requester arbiter and sequencer for the uFork quad-cell memory (`quad_mem`). Each requester issues whole-quad reads or writes (T, X, Y, Z as one 64-bit operation). The block grants one requester at a time using round-robin priority, then sequences the four single-field accesses. It drives the memory's chip selects, address, field and data, absorbs the one-cycle read latency, and returns the assembled quad. It sits between the evaluator core (port A) and the loader/GC engine (port B) on one side and `quad_mem` on the other.

---
 rtl/quad_mem_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/quad_mem_arb.sv
// Round-robin arbiter for two quad requesters that sequences each whole-quad
// access into four single-field quad_mem cycles and reassembles read data.
module quad_mem_arb #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_a_req,
    input  logic                   i_a_wr,
    input  logic [1:0]             i_a_sel,
    input  logic [ADDR_SZ-1:0]     i_a_addr,
    input  logic [4*DATA_SZ-1:0]   i_a_wdata,
    input  logic                   i_b_req,
    input  logic                   i_b_wr,
    input  logic [1:0]             i_b_sel,
    input  logic [ADDR_SZ-1:0]     i_b_addr,
    input  logic [4*DATA_SZ-1:0]   i_b_wdata,
    output logic                   o_a_ack,
    output logic                   o_b_ack,
    output logic                   o_err,
    output logic [4*DATA_SZ-1:0]   o_rdata,
    output logic                   o_busy,
    output logic                   o_mem_cs_ram,
    output logic                   o_mem_cs_rom0,
    output logic                   o_mem_cs_rom1,
    output logic                   o_mem_wr,
    output logic [ADDR_SZ-1:0]     o_mem_addr,
    output logic [1:0]             o_mem_field,
    output logic [DATA_SZ-1:0]     o_mem_data,
    input  logic [DATA_SZ-1:0]     i_mem_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state, state_nx;
    logic [1:0]             f;
    logic                   last;       // 0: A was granted last, 1: B
    logic                   win;        // owner of the operation in progress
    logic                   cmd_wr;
    logic [1:0]             cmd_sel;
    logic [ADDR_SZ-1:0]     cmd_addr;
    logic [4*DATA_SZ-1:0]   cmd_wdata;
    logic [4*DATA_SZ-1:0]   rdata;
    logic                   any_req;
    logic                   grant_b;
    logic                   issue;
    logic                   done;
    logic [1:0]             f_prev;
    logic [DATA_SZ-1:0]     cap;

    assign any_req = i_a_req | i_b_req;
    // B wins when alone, or on a tie when A was served last.
    assign grant_b = i_b_req & (~i_a_req | ~last);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   if (f == 2'd3) state_nx = cmd_wr ? DONE : WAIT;
            WAIT:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            f     <= 2'd0;
            last  <= 1'b1;
            win   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                f <= 2'd0;
                if (any_req) begin
                    win  <= grant_b;
                    last <= grant_b;
                end
            end else if (state == ISSUE) begin
                f <= f + 2'd1;
            end
        end
    end

    // Command is only consumed while busy, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && any_req) begin
            cmd_wr    <= grant_b ? i_b_wr    : i_a_wr;
            cmd_sel   <= grant_b ? i_b_sel   : i_a_sel;
            cmd_addr  <= grant_b ? i_b_addr  : i_a_addr;
            cmd_wdata <= grant_b ? i_b_wdata : i_a_wdata;
        end
    end

    assign f_prev = f - 2'd1;
    assign cap    = (cmd_sel == 2'd3) ? '0 : i_mem_data;

    // Read data lags the issued field by one cycle; Z lands during WAIT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata <= '0;
        end else if (!cmd_wr) begin
            if (state == ISSUE && f != 2'd0)
                rdata[DATA_SZ*f_prev +: DATA_SZ] <= cap;
            else if (state == WAIT)
                rdata[3*DATA_SZ +: DATA_SZ] <= cap;
        end
    end

    assign issue = (state == ISSUE);
    assign done  = (state == DONE);

    assign o_mem_cs_ram  = issue & (cmd_sel == 2'd0);
    assign o_mem_cs_rom0 = issue & (cmd_sel == 2'd1);
    assign o_mem_cs_rom1 = issue & (cmd_sel == 2'd2);
    assign o_mem_wr      = issue & cmd_wr;
    assign o_mem_field   = issue ? f : 2'd0;
    assign o_mem_addr    = issue ? cmd_addr : '0;
    assign o_mem_data    = issue ? cmd_wdata[DATA_SZ*f +: DATA_SZ] : '0;

    assign o_a_ack = done & ~win;
    assign o_b_ack = done & win;
    assign o_err   = done & (cmd_sel == 2'd3);
    assign o_busy  = (state != IDLE);
    assign o_rdata = rdata;

endmodule
